// File: rtl/spi_rx_word_checker_if.sv
// Bus between the SPI receiver/consumer and spi_rx_word_checker: frame input,
// FIFO read port and checker status.
interface spi_rx_word_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ERR_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] rx_word;
  logic             rx_done;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [LW-1:0]    level;
  logic             seq_error;
  logic [ERR_W-1:0] err_count;
  logic             overflow;
  logic             chk_state;

  modport master (
    output rx_word, rx_done, rd_en,
    input  rd_data, rd_valid, empty, full, level,
           seq_error, err_count, overflow, chk_state
  );

  modport slave (
    input  rx_word, rx_done, rd_en,
    output rd_data, rd_valid, empty, full, level,
           seq_error, err_count, overflow, chk_state
  );
endinterface

// File: rtl/spi_rx_word_checker.sv
// Captures one word per SPI frame-done high period into a FIFO and checks the
// words against the transmitter's wrapping counter sequence.
module spi_rx_word_checker #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int WRAP_VAL = 256,
  parameter int ERR_W    = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  spi_rx_word_checker_if.slave bus
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int LW   = ADDR + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [WIDTH-1:0] WRAP_W   = WIDTH'(WRAP_VAL);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} chk_state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q;
  logic             done_q;
  logic             capture, rd_ok, wr_ok;
  logic [WIDTH-1:0] rd_data_q, expected, nxt_word;
  logic             rd_valid_q, seq_error_q, overflow_q;
  logic [ERR_W-1:0] err_count_q;
  chk_state_t       state;

  // A read accepted while full frees the slot, so a same-cycle capture is kept.
  always_comb begin
    capture  = bus.rx_done & ~done_q;
    rd_ok    = bus.rd_en & (level_q != '0);
    wr_ok    = capture & ((level_q != FULL_LVL) | rd_ok);
    nxt_word = (bus.rx_word == WRAP_W) ? '0 : bus.rx_word + WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ptr] <= bus.rx_word;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      done_q      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      seq_error_q <= 1'b0;
      err_count_q <= '0;
      overflow_q  <= 1'b0;
      expected    <= '0;
      state       <= HUNT;
    end else begin
      done_q      <= bus.rx_done;
      rd_valid_q  <= rd_ok;
      seq_error_q <= 1'b0;
      if (wr_ok) wr_ptr <= wr_ptr + ADDR'(1);
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + ADDR'(1);
        rd_data_q <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (capture && !wr_ok) overflow_q <= 1'b1;
      // Dropped words still advance the checker so it mirrors the sender.
      if (capture) begin
        expected <= nxt_word;
        state    <= TRACK;
        if (state == TRACK && bus.rx_word != expected) begin
          seq_error_q <= 1'b1;
          if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.empty     = (level_q == '0);
  assign bus.full      = (level_q == FULL_LVL);
  assign bus.level     = level_q;
  assign bus.seq_error = seq_error_q;
  assign bus.err_count = err_count_q;
  assign bus.overflow  = overflow_q;
  assign bus.chk_state = state;
endmodule

// File: tb/tb_spi_rx_word_checker.sv
// Directed bench for spi_rx_word_checker: frame table plus hand-written FIFO
// boundary and reset sequences.
module tb_spi_rx_word_checker;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int WRAP_VAL = 256;
  localparam int ERR_W    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_rx_word_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_W(ERR_W)) bus ();

  spi_rx_word_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP_VAL(WRAP_VAL), .ERR_W(ERR_W)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic        rd;
    logic        exp_err;
    logic [15:0] exp_cnt;
    logic [4:0]  exp_level;
    logic        exp_rdv;
  } vec_t;

  vec_t vecs [13];

  int n_checks = 0;
  int n_pass   = 0;
  int rdv_seen = 0;
  int seq_seen = 0;
  int snap;

  logic        s_se, s_rdv;
  logic [4:0]  s_lv;
  logic [31:0] s_rdd;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) rdv_seen++;
    if (bus.seq_error === 1'b1) seq_seen++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.rx_done = 1'b0;
    bus.rd_en = 1'b0;
    bus.rx_word = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // One frame with rx_done high for 3 cycles; outputs sampled just after capture.
  task automatic send(input logic [31:0] w, input logic rd, output logic se,
                      output logic [4:0] lv, output logic rdv, output logic [31:0] rdd);
    bus.rx_word = w;
    bus.rx_done = 1'b1;
    bus.rd_en = rd;
    tick;
    se = bus.seq_error;
    lv = bus.level;
    rdv = bus.rd_valid;
    rdd = bus.rd_data;
    bus.rd_en = 1'b0;
    tick;
    tick;
    bus.rx_done = 1'b0;
    tick;
  endtask

  task automatic pop(input logic [31:0] exp, input string name);
    bus.rd_en = 1'b1;
    tick;
    bus.rd_en = 1'b0;
    check({name, " rd_valid"}, bus.rd_valid, 1);
    check({name, " rd_data"}, bus.rd_data, exp);
    tick;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(vecs[i].word, vecs[i].rd, s_se, s_lv, s_rdv, s_rdd);
      check($sformatf("v%0d seq_error", i), s_se, vecs[i].exp_err);
      check($sformatf("v%0d level", i), s_lv, vecs[i].exp_level);
      check($sformatf("v%0d err_count", i), bus.err_count, vecs[i].exp_cnt);
      check($sformatf("v%0d rd_valid", i), s_rdv, vecs[i].exp_rdv);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++)
      vecs[i] = '{word: 32'(i), rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd0,
                  exp_level: 5'(i + 1), exp_rdv: 1'b0};
    vecs[5]  = '{word: 32'd255, rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd0, exp_level: 5'd1, exp_rdv: 1'b0};
    vecs[6]  = '{word: 32'd256, rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd0, exp_level: 5'd2, exp_rdv: 1'b0};
    vecs[7]  = '{word: 32'd0,   rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd0, exp_level: 5'd3, exp_rdv: 1'b0};
    vecs[8]  = '{word: 32'd1,   rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd0, exp_level: 5'd4, exp_rdv: 1'b0};
    vecs[9]  = '{word: 32'd10,  rd: 1'b1, exp_err: 1'b0, exp_cnt: 16'd0, exp_level: 5'd1, exp_rdv: 1'b0};
    vecs[10] = '{word: 32'd11,  rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd0, exp_level: 5'd2, exp_rdv: 1'b0};
    vecs[11] = '{word: 32'd15,  rd: 1'b0, exp_err: 1'b1, exp_cnt: 16'd1, exp_level: 5'd3, exp_rdv: 1'b0};
    vecs[12] = '{word: 32'd16,  rd: 1'b0, exp_err: 1'b0, exp_cnt: 16'd1, exp_level: 5'd4, exp_rdv: 1'b0};

    bus.rx_word = '0;
    bus.rx_done = 1'b0;
    bus.rd_en = 1'b0;
    do_reset;
    check("reset rd_data", bus.rd_data, 0);
    check("reset rd_valid", bus.rd_valid, 0);
    check("reset empty", bus.empty, 1);
    check("reset full", bus.full, 0);
    check("reset level", bus.level, 0);
    check("reset seq_error", bus.seq_error, 0);
    check("reset err_count", bus.err_count, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset chk_state", bus.chk_state, 0);

    // Counting frames 0..4, then drain.
    run_vecs(0, 4);
    check("count level", bus.level, 5);
    check("count chk_state", bus.chk_state, 1);
    snap = rdv_seen;
    for (int i = 0; i < 5; i++) pop(32'(i), $sformatf("count pop%0d", i));
    bus.rd_en = 1'b1;
    tick;
    bus.rd_en = 1'b0;
    check("empty read rd_valid", bus.rd_valid, 0);
    check("empty read rd_data hold", bus.rd_data, 4);
    tick;
    check("count rd_valid pulses", rdv_seen - snap, 5);
    check("count err_count", bus.err_count, 0);
    check("count empty", bus.empty, 1);

    // Wrap through WRAP_VAL.
    do_reset;
    run_vecs(5, 8);
    pop(32'd255, "wrap pop0");
    pop(32'd256, "wrap pop1");
    pop(32'd0, "wrap pop2");
    pop(32'd1, "wrap pop3");

    // Gap in the sequence, starting with capture+read while empty.
    do_reset;
    snap = seq_seen;
    run_vecs(9, 12);
    check("gap seq_error pulses", seq_seen - snap, 1);

    // Fill, capture+read while full, then overflow drops.
    do_reset;
    for (int i = 0; i < 16; i++) send(32'(i), 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("fill full", bus.full, 1);
    check("fill level", bus.level, 16);
    check("fill overflow", bus.overflow, 0);
    send(32'd16, 1'b1, s_se, s_lv, s_rdv, s_rdd);
    check("full rw rd_valid", s_rdv, 1);
    check("full rw rd_data", s_rdd, 0);
    check("full rw level", s_lv, 16);
    check("full rw overflow", bus.overflow, 0);
    send(32'd17, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    send(32'd18, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("drop overflow", bus.overflow, 1);
    check("drop level", bus.level, 16);
    for (int i = 1; i <= 16; i++) pop(32'(i), $sformatf("full pop%0d", i));
    check("full drained empty", bus.empty, 1);
    check("full err_count", bus.err_count, 0);
    check("full overflow sticky", bus.overflow, 1);

    // Reset during activity, then restart in HUNT.
    do_reset;
    send(32'd5, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    send(32'd6, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    send(32'd9, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("pre-reset err_count", bus.err_count, 1);
    check("pre-reset level", bus.level, 3);
    check("pre-reset chk_state", bus.chk_state, 1);
    bus.rx_word = 32'd20;
    bus.rx_done = 1'b1;
    bus.rd_en = 1'b1;
    reset = 1'b1;
    tick;
    check("mid reset empty", bus.empty, 1);
    check("mid reset level", bus.level, 0);
    check("mid reset err_count", bus.err_count, 0);
    check("mid reset chk_state", bus.chk_state, 0);
    check("mid reset rd_valid", bus.rd_valid, 0);
    check("mid reset rd_data", bus.rd_data, 0);
    reset = 1'b0;
    bus.rx_done = 1'b0;
    bus.rd_en = 1'b0;
    tick;
    send(32'd42, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("hunt 42 seq_error", s_se, 0);
    check("hunt 42 level", s_lv, 1);
    check("hunt 42 chk_state", bus.chk_state, 1);
    send(32'd43, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("track 43 seq_error", s_se, 0);
    send(32'd300, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("above wrap seq_error", s_se, 1);
    check("above wrap err_count", bus.err_count, 1);
    send(32'd301, 1'b0, s_se, s_lv, s_rdv, s_rdd);
    check("after 300 seq_error", s_se, 0);
    check("after 300 err_count", bus.err_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
